// File: rtl/lvds_align_pkg.sv
// -----------------------------------------------------------------------------
// lvds_align_pkg
// Shared definitions for the LVDS word-alignment link. The receive aligner
// and the transmit training generator both import this package so that
// the training word and the slip budget are defined in one place.
//
// Contents:
//   SERDES_FACTOR          deserialization ratio of the LVDS link
//   DEFAULT_TRAIN_PATTERN  word sent by the transmitter during training
//   DEFAULT_MAX_SLIPS      slip budget, one full rotation of the word
//   align_state_t          state encoding of the receive aligner FSM
//   rotl8()                rotate a word left; models a misaligned boundary
// -----------------------------------------------------------------------------
package lvds_align_pkg;

    localparam int unsigned SERDES_FACTOR         = 8;
    localparam logic [7:0]  DEFAULT_TRAIN_PATTERN = 8'hF1;
    localparam int unsigned DEFAULT_MAX_SLIPS     = SERDES_FACTOR;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_SLIP    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_ALIGNED = 3'd4,
        ST_FAIL    = 3'd5
    } align_state_t;

    // A word whose boundary is off by n bits looks like the original word
    // rotated by n; the tx generator and models use this to build such words.
    function automatic logic [7:0] rotl8(input logic [7:0] word, input logic [2:0] n);
        logic [15:0] doubled;
        doubled = {word, word} << n;
        return doubled[15:8];
    endfunction

endpackage

// File: rtl/lvds_rx_align.sv
// -----------------------------------------------------------------------------
// lvds_rx_align
// Word-boundary aligner for an LVDS deserializer. While training is
// requested, incoming words are compared against the known training word.
// A mismatch issues a one-cycle bitslip pulse to the deserializer, waits
// for the new boundary to settle, and compares again. MATCH_COUNT
// consecutive matches declare alignment; running out of slips declares
// failure. Once aligned, the link stays up until PLL lock is lost.
//
// Parameters:
//   TRAIN_PATTERN  training word sent by the transmitter
//   MATCH_COUNT    consecutive matching words needed for alignment
//   SLIP_WAIT      settle cycles after a slip before comparing again
//   MAX_SLIPS      slip budget (serialization factor)
//
// Ports:
//   clk            rx core clock (rx_outclock domain)
//   rst_n          asynchronous active-low reset, deasserted synchronously
//                  by the parent
//   rx_locked      deserializer PLL lock
//   train_en       level; high requests or maintains training
//   rx_data        parallel word from the deserializer
//   rx_data_align  bitslip pulse to the deserializer
//   aligned        word boundary found
//   align_fail     slip budget exhausted without alignment
//   slip_cnt       slips issued since training start, saturating
//   data_out       registered rx_data, valid only while aligned
//   data_valid     qualifies data_out
// -----------------------------------------------------------------------------
module lvds_rx_align
    import lvds_align_pkg::*;
#(
    parameter logic [7:0]  TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
    parameter int unsigned MATCH_COUNT   = 4,
    parameter int unsigned SLIP_WAIT     = 3,
    parameter int unsigned MAX_SLIPS     = DEFAULT_MAX_SLIPS
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_locked,
    input  logic       train_en,
    input  logic [7:0] rx_data,
    output logic       rx_data_align,
    output logic       aligned,
    output logic       align_fail,
    output logic [3:0] slip_cnt,
    output logic [7:0] data_out,
    output logic       data_valid
);

    localparam int unsigned MATCH_W   = (MATCH_COUNT < 2) ? 1 : $clog2(MATCH_COUNT + 1);
    localparam int unsigned WAIT_W    = (SLIP_WAIT < 2) ? 1 : $clog2(SLIP_WAIT + 1);
    localparam int unsigned WAIT_LAST = (SLIP_WAIT == 0) ? 0 : SLIP_WAIT - 1;
    localparam int unsigned MATCH_LST = (MATCH_COUNT == 0) ? 0 : MATCH_COUNT - 1;

    localparam logic [MATCH_W-1:0] MATCH_MAX  = MATCH_W'(MATCH_COUNT);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(MATCH_LST);
    localparam logic [WAIT_W-1:0]  WAIT_END   = WAIT_W'(WAIT_LAST);
    localparam logic [3:0]         SLIP_MAX   = 4'(MAX_SLIPS);

    align_state_t       r_state;
    logic [MATCH_W-1:0] r_match_cnt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [3:0]         r_slip_cnt;
    logic               r_rx_data_align;
    logic               r_aligned;
    logic               r_align_fail;
    logic               r_data_valid;
    logic [7:0]         r_data_out;

    align_state_t       w_next_state;
    logic [MATCH_W-1:0] w_next_match;
    logic [WAIT_W-1:0]  w_next_wait;
    logic [3:0]         w_next_slip;
    logic               w_word_match;

    assign w_word_match = (rx_data == TRAIN_PATTERN);

    // Next-state and counter logic. slip_cnt is bumped on the edge that
    // enters SLIP so the count is visible together with the bitslip pulse.
    // Loss of PLL lock is applied last so that it overrides every other
    // transition, and any return to IDLE clears the training counters.
    always_comb begin
        w_next_state = r_state;
        w_next_match = r_match_cnt;
        w_next_wait  = r_wait_cnt;
        w_next_slip  = r_slip_cnt;

        case (r_state)
            ST_IDLE: begin
                w_next_match = '0;
                w_next_wait  = '0;
                w_next_slip  = '0;
                if (rx_locked && train_en) begin
                    w_next_state = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (!train_en) begin
                    w_next_state = ST_IDLE;
                end else if (w_word_match) begin
                    if (r_match_cnt < MATCH_MAX) begin
                        w_next_match = r_match_cnt + 1'b1;
                    end
                    if (r_match_cnt >= MATCH_LAST) begin
                        w_next_state = ST_ALIGNED;
                    end
                end else begin
                    w_next_match = '0;
                    if (r_slip_cnt >= SLIP_MAX) begin
                        w_next_state = ST_FAIL;
                    end else begin
                        w_next_state = ST_SLIP;
                        w_next_slip  = r_slip_cnt + 1'b1;
                    end
                end
            end

            ST_SLIP: begin
                w_next_wait = '0;
                if (!train_en) begin
                    w_next_state = ST_IDLE;
                end else if (SLIP_WAIT == 0) begin
                    w_next_state = ST_CHECK;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // rx_data is ignored here; the deserializer output is
                // still settling after the slip.
                if (!train_en) begin
                    w_next_state = ST_IDLE;
                end else if (r_wait_cnt >= WAIT_END) begin
                    w_next_state = ST_CHECK;
                end else begin
                    w_next_wait = r_wait_cnt + 1'b1;
                end
            end

            ST_ALIGNED: begin
                // Link stays up regardless of train_en.
                w_next_state = ST_ALIGNED;
            end

            ST_FAIL: begin
                if (!train_en) begin
                    w_next_state = ST_IDLE;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        if (r_state != ST_IDLE && !rx_locked) begin
            w_next_state = ST_IDLE;
        end

        if (w_next_state == ST_IDLE) begin
            w_next_match = '0;
            w_next_wait  = '0;
            w_next_slip  = '0;
        end
    end

    // State, counters and registered outputs. Outputs are decoded from the
    // next state so each one changes on the same edge as the state itself;
    // the async reset drops a pending bitslip pulse without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_match_cnt     <= '0;
            r_wait_cnt      <= '0;
            r_slip_cnt      <= '0;
            r_rx_data_align <= 1'b0;
            r_aligned       <= 1'b0;
            r_align_fail    <= 1'b0;
            r_data_valid    <= 1'b0;
            r_data_out      <= 8'h00;
        end else begin
            r_state         <= w_next_state;
            r_match_cnt     <= w_next_match;
            r_wait_cnt      <= w_next_wait;
            r_slip_cnt      <= w_next_slip;
            r_rx_data_align <= (w_next_state == ST_SLIP);
            r_aligned       <= (w_next_state == ST_ALIGNED);
            r_data_valid    <= (w_next_state == ST_ALIGNED);
            r_align_fail    <= (w_next_state == ST_FAIL);
            if (w_next_state == ST_ALIGNED) begin
                r_data_out <= rx_data;
            end
        end
    end

    assign rx_data_align = r_rx_data_align;
    assign aligned       = r_aligned;
    assign align_fail    = r_align_fail;
    assign slip_cnt      = r_slip_cnt;
    assign data_out      = r_data_out;
    assign data_valid    = r_data_valid;

endmodule

// File: tb/tb_lvds_rx_align.sv
// -----------------------------------------------------------------------------
// tb_lvds_rx_align
// Self-checking bench for lvds_rx_align with default parameters. Each
// scenario task drives the aligner and compares its outputs against values
// derived from the intended behaviour; aligned data is tracked with a
// queue of words driven and popped as data_out presents them.
// -----------------------------------------------------------------------------
module tb_lvds_rx_align;
    import lvds_align_pkg::*;

    localparam logic [7:0] PATTERN  = 8'hF1;
    localparam int         MATCHES  = 4;
    localparam int         SLIP_GAP = 3;
    localparam int         SLIPS    = 8;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       rxLocked = 1'b0;
    logic       trainEn  = 1'b0;
    logic [7:0] rxData   = 8'h00;

    logic       rxDataAlign;
    logic       aligned;
    logic       alignFail;
    logic [3:0] slipCnt;
    logic [7:0] dataOut;
    logic       dataValid;

    int errorCount = 0;
    int checkCount = 0;

    // Bitslip monitor, updated once per sampled cycle.
    int cycle      = 0;
    int pulseCount = 0;
    int lastPulse  = -1000;
    int minGap     = 1000;
    bit doubleHigh = 1'b0;
    bit prevAlign  = 1'b0;

    logic [7:0] expQ[$];

    lvds_rx_align dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_locked    (rxLocked),
        .train_en     (trainEn),
        .rx_data      (rxData),
        .rx_data_align(rxDataAlign),
        .aligned      (aligned),
        .align_fail   (alignFail),
        .slip_cnt     (slipCnt),
        .data_out     (dataOut),
        .data_valid   (dataValid)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
        if (rxDataAlign) begin
            if (prevAlign) doubleHigh = 1'b1;
            if (cycle - lastPulse < minGap) minGap = cycle - lastPulse;
            lastPulse = cycle;
            pulseCount++;
        end
        prevAlign = rxDataAlign;
    endtask

    task automatic clearMonitor();
        pulseCount = 0;
        lastPulse  = -1000;
        minGap     = 1000;
        doubleHigh = 1'b0;
    endtask

    // Drop lock and training for two cycles so every scenario starts in IDLE.
    task automatic goIdle();
        rxLocked = 1'b0;
        trainEn  = 1'b0;
        tick();
        tick();
        rxLocked = 1'b1;
    endtask

    task automatic test_reset();
        rxLocked = 1'b0;
        trainEn  = 1'b0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        checkCount++; if (rxDataAlign !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_slip_pulse: got %b expected 0", rxDataAlign); end
        checkCount++; if (aligned !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_aligned: got %b expected 0", aligned); end
        checkCount++; if (alignFail !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_align_fail: got %b expected 0", alignFail); end
        checkCount++; if (dataValid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_data_valid: got %b expected 0", dataValid); end
        checkCount++; if (slipCnt !== 4'd0) begin errorCount++; $display("[TB] FAIL reset_slip_cnt: got %0d expected 0", slipCnt); end
        checkCount++; if (dataOut !== 8'h00) begin errorCount++; $display("[TB] FAIL reset_data_out: got %h expected 00", dataOut); end
        rst_n = 1'b1;
        tick();
    endtask

    // Correct boundary from the start: one cycle to leave IDLE, then
    // MATCHES matching words, alignment on the last of them.
    task automatic test_no_slip();
        goIdle();
        clearMonitor();
        rxData  = PATTERN;
        trainEn = 1'b1;
        for (int i = 1; i <= 1 + MATCHES; i++) begin
            tick();
            if (i == MATCHES) begin
                checkCount++; if (aligned !== 1'b0) begin errorCount++; $display("[TB] FAIL noslip_early_align: got %b expected 0", aligned); end
            end
        end
        checkCount++; if (aligned !== 1'b1) begin errorCount++; $display("[TB] FAIL noslip_aligned: got %b expected 1", aligned); end
        checkCount++; if (dataValid !== 1'b1) begin errorCount++; $display("[TB] FAIL noslip_data_valid: got %b expected 1", dataValid); end
        checkCount++; if (pulseCount !== 0) begin errorCount++; $display("[TB] FAIL noslip_pulses: got %0d expected 0", pulseCount); end
        checkCount++; if (slipCnt !== 4'd0) begin errorCount++; $display("[TB] FAIL noslip_slip_cnt: got %0d expected 0", slipCnt); end
        checkCount++; if (dataOut !== PATTERN) begin errorCount++; $display("[TB] FAIL noslip_data_out: got %h expected %h", dataOut, PATTERN); end
    endtask

    // Deserializer model: the boundary is off until three slips are seen.
    task automatic test_slip();
        logic [7:0] skewed;
        skewed = rotl8(PATTERN, 3'd3);
        goIdle();
        clearMonitor();
        rxData  = skewed;
        trainEn = 1'b1;
        for (int i = 0; i < 100 && !aligned; i++) begin
            tick();
            rxData = (pulseCount >= 3) ? PATTERN : skewed;
        end
        checkCount++; if (aligned !== 1'b1) begin errorCount++; $display("[TB] FAIL slip_aligned: got %b expected 1 within 100 cycles", aligned); end
        checkCount++; if (pulseCount !== 3) begin errorCount++; $display("[TB] FAIL slip_pulses: got %0d expected 3", pulseCount); end
        checkCount++; if (slipCnt !== 4'd3) begin errorCount++; $display("[TB] FAIL slip_slip_cnt: got %0d expected 3", slipCnt); end
        checkCount++; if (doubleHigh !== 1'b0) begin errorCount++; $display("[TB] FAIL slip_pulse_width: got double-high %b expected 0", doubleHigh); end
        checkCount++; if (minGap !== SLIP_GAP + 2) begin errorCount++; $display("[TB] FAIL slip_pulse_gap: got %0d expected %0d", minGap, SLIP_GAP + 2); end
    endtask

    task automatic test_fail();
        int heldPulses;
        goIdle();
        clearMonitor();
        rxData  = 8'h22;
        trainEn = 1'b1;
        for (int i = 0; i < 200 && !alignFail; i++) tick();
        checkCount++; if (alignFail !== 1'b1) begin errorCount++; $display("[TB] FAIL fail_flag: got %b expected 1 within 200 cycles", alignFail); end
        checkCount++; if (pulseCount !== SLIPS) begin errorCount++; $display("[TB] FAIL fail_pulses: got %0d expected %0d", pulseCount, SLIPS); end
        checkCount++; if (slipCnt !== 4'(SLIPS)) begin errorCount++; $display("[TB] FAIL fail_slip_cnt: got %0d expected %0d", slipCnt, SLIPS); end
        checkCount++; if (aligned !== 1'b0) begin errorCount++; $display("[TB] FAIL fail_aligned: got %b expected 0", aligned); end
        checkCount++; if (minGap !== SLIP_GAP + 2) begin errorCount++; $display("[TB] FAIL fail_pulse_gap: got %0d expected %0d", minGap, SLIP_GAP + 2); end
        heldPulses = pulseCount;
        for (int i = 0; i < 6; i++) tick();
        checkCount++; if (pulseCount !== heldPulses) begin errorCount++; $display("[TB] FAIL fail_no_more_slips: got %0d pulses expected %0d", pulseCount, heldPulses); end
        checkCount++; if (alignFail !== 1'b1) begin errorCount++; $display("[TB] FAIL fail_flag_held: got %b expected 1", alignFail); end
        trainEn = 1'b0;
        tick();
        checkCount++; if (alignFail !== 1'b0) begin errorCount++; $display("[TB] FAIL fail_release: got %b expected 0", alignFail); end
        checkCount++; if (slipCnt !== 4'd0) begin errorCount++; $display("[TB] FAIL fail_release_slip_cnt: got %0d expected 0", slipCnt); end
    endtask

    // Aligned data path through the scoreboard, then loss of lock.
    task automatic test_data();
        logic [7:0] stream [6] = '{8'h22, 8'h5A, 8'h00, 8'hFF, 8'h5A, 8'h22};
        logic [7:0] expWord;
        goIdle();
        rxData  = PATTERN;
        trainEn = 1'b1;
        for (int i = 0; i < 50 && !aligned; i++) tick();
        checkCount++; if (aligned !== 1'b1) begin errorCount++; $display("[TB] FAIL data_align: got %b expected 1 within 50 cycles", aligned); end
        expQ.delete();
        for (int i = 0; i < 6; i++) begin
            rxData = stream[i];
            expQ.push_back(stream[i]);
            if (i == 2) trainEn = 1'b0;
            tick();
            checkCount++; if (dataValid !== 1'b1) begin errorCount++; $display("[TB] FAIL data_valid_%0d: got %b expected 1", i, dataValid); end
            if (dataValid === 1'b1 && expQ.size() > 0) begin
                expWord = expQ.pop_front();
                checkCount++; if (dataOut !== expWord) begin errorCount++; $display("[TB] FAIL data_out_%0d: got %h expected %h", i, dataOut, expWord); end
            end
        end
        checkCount++; if (expQ.size() !== 0) begin errorCount++; $display("[TB] FAIL data_queue_drain: got %0d left expected 0", expQ.size()); end
        rxLocked = 1'b0;
        tick();
        checkCount++; if (aligned !== 1'b0) begin errorCount++; $display("[TB] FAIL data_unlock_aligned: got %b expected 0", aligned); end
        checkCount++; if (dataValid !== 1'b0) begin errorCount++; $display("[TB] FAIL data_unlock_valid: got %b expected 0", dataValid); end
    endtask

    task automatic test_reset_mid_slip();
        int ticks;
        goIdle();
        rxData  = 8'h22;
        trainEn = 1'b1;
        for (int i = 0; i < 20 && !rxDataAlign; i++) tick();
        checkCount++; if (rxDataAlign !== 1'b1) begin errorCount++; $display("[TB] FAIL midslip_pulse_seen: got %b expected 1 within 20 cycles", rxDataAlign); end
        #2 rst_n = 1'b0;
        #1;
        checkCount++; if (rxDataAlign !== 1'b0) begin errorCount++; $display("[TB] FAIL midslip_async_drop: got %b expected 0", rxDataAlign); end
        checkCount++; if (slipCnt !== 4'd0) begin errorCount++; $display("[TB] FAIL midslip_slip_cnt: got %0d expected 0", slipCnt); end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rxData    = PATTERN;
        prevAlign = 1'b0;
        clearMonitor();
        ticks = 0;
        for (int i = 0; i < 20 && !aligned; i++) begin
            tick();
            ticks++;
        end
        checkCount++; if (ticks !== 1 + MATCHES) begin errorCount++; $display("[TB] FAIL midslip_restart_latency: got %0d cycles expected %0d", ticks, 1 + MATCHES); end
        checkCount++; if (slipCnt !== 4'd0) begin errorCount++; $display("[TB] FAIL midslip_restart_slip_cnt: got %0d expected 0", slipCnt); end
        checkCount++; if (pulseCount !== 0) begin errorCount++; $display("[TB] FAIL midslip_restart_pulses: got %0d expected 0", pulseCount); end
    endtask

    // Cycle budget: 1 to leave IDLE, 3 matches, 1 mismatch, 1 slip,
    // SLIP_GAP waits, then MATCHES fresh matches -> aligned at cycle 13.
    task automatic test_match_restart();
        int alignAt;
        alignAt = 1 + 3 + 1 + 1 + SLIP_GAP + MATCHES;
        goIdle();
        clearMonitor();
        trainEn = 1'b1;
        for (int i = 1; i <= alignAt; i++) begin
            rxData = (i == 5) ? 8'h22 : PATTERN;
            tick();
            if (i == alignAt - 1) begin
                checkCount++; if (aligned !== 1'b0) begin errorCount++; $display("[TB] FAIL restart_early_align: got %b expected 0", aligned); end
            end
        end
        checkCount++; if (aligned !== 1'b1) begin errorCount++; $display("[TB] FAIL restart_aligned: got %b expected 1", aligned); end
        checkCount++; if (pulseCount !== 1) begin errorCount++; $display("[TB] FAIL restart_pulses: got %0d expected 1", pulseCount); end
        checkCount++; if (slipCnt !== 4'd1) begin errorCount++; $display("[TB] FAIL restart_slip_cnt: got %0d expected 1", slipCnt); end
    endtask

    initial begin
        test_reset();
        test_no_slip();
        test_slip();
        test_fail();
        test_data();
        test_reset_mid_slip();
        test_match_restart();
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
